// File: rtl/demux2_stream.sv
// 1-to-2 valid/ready stream demultiplexer with a single-entry holding register
// and per-output transfer counters.
module demux2_stream #(
   parameter int n  = 4,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [n-1:0]  in_data,
   input  logic          in_sel,
   output logic          out0_valid,
   input  logic          out0_ready,
   output logic [n-1:0]  out0_data,
   output logic          out1_valid,
   input  logic          out1_ready,
   output logic [n-1:0]  out1_data,
   input  logic          cnt_clr,
   output logic [CW-1:0] cnt0,
   output logic [CW-1:0] cnt1
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL0 = 2'd1,
      FULL1 = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [n-1:0]  data_reg, data_next;
   logic [1:0]    out_valid;
   logic [1:0]    out_ready;
   logic [1:0]    out_xfer;
   logic [CW-1:0] cnt_reg [2];

   assign out_ready = {out1_ready, out0_ready};
   assign out_xfer  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
      end
   end

   // A draining slot may be refilled on the same edge, so in_ready follows the active sink.
   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      in_ready   = 1'b0;
      out_valid  = 2'b00;
      case (state_reg)
         EMPTY: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_next  = in_data;
               state_next = in_sel ? FULL1 : FULL0;
            end
         end
         FULL0, FULL1: begin
            if (state_reg == FULL0) begin
               out_valid = 2'b01;
               in_ready  = out0_ready;
            end else begin
               out_valid = 2'b10;
               in_ready  = out1_ready;
            end
            if (in_ready) begin
               if (in_valid) begin
                  data_next  = in_data;
                  state_next = in_sel ? FULL1 : FULL0;
               end else begin
                  state_next = EMPTY;
               end
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg[gi] <= '0;
            end else if (cnt_clr) begin
               cnt_reg[gi] <= '0;
            end else if (out_xfer[gi]) begin
               cnt_reg[gi] <= cnt_reg[gi] + CW'(1);
            end
         end
      end
   endgenerate

   assign out0_valid = out_valid[0];
   assign out1_valid = out_valid[1];
   assign out0_data  = data_reg;
   assign out1_data  = data_reg;
   assign cnt0       = cnt_reg[0];
   assign cnt1       = cnt_reg[1];

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: directed scenarios plus random traffic, checked
// against a queue-based transaction model.
module tb_demux2_stream;

   localparam int N  = 4;
   localparam int CW = 3;
   localparam int CMOD = 1 << CW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  in_data = '0;
   logic          in_sel = 1'b0;
   logic          out0_valid, out1_valid;
   logic          out0_ready = 1'b0, out1_ready = 1'b0;
   logic [N-1:0]  out0_data, out1_data;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] cnt0, cnt1;

   demux2_stream #(.n(N), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
      .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] d;
      logic         s;
   } word_t;

   word_t        q[$];
   logic [N-1:0] m_buf;
   int           m_cnt[2];
   int           tests_run = 0;
   int           tests_failed = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string pfx);
      logic exp_rdy, exp_v0, exp_v1;
      exp_v0  = (q.size() > 0) && (q[0].s == 1'b0);
      exp_v1  = (q.size() > 0) && (q[0].s == 1'b1);
      exp_rdy = (q.size() == 0) || (exp_v0 && out0_ready) || (exp_v1 && out1_ready);
      check_eq({pfx, "in_ready"}, 32'(in_ready), 32'(exp_rdy));
      check_eq({pfx, "out0_valid"}, 32'(out0_valid), 32'(exp_v0));
      check_eq({pfx, "out1_valid"}, 32'(out1_valid), 32'(exp_v1));
      check_eq({pfx, "out0_data"}, 32'(out0_data), 32'(m_buf));
      check_eq({pfx, "out1_data"}, 32'(out1_data), 32'(m_buf));
      check_eq({pfx, "cnt0"}, 32'(cnt0), 32'(m_cnt[0]));
      check_eq({pfx, "cnt1"}, 32'(cnt1), 32'(m_cnt[1]));
   endtask

   // Called at a negedge: drive, check combinational view, then apply the edge to the model.
   task automatic cycle(input logic iv, input logic [N-1:0] id, input logic is,
                        input logic r0, input logic r1, input logic clr);
      logic ox, ix;
      logic s;
      in_valid = iv; in_data = id; in_sel = is;
      out0_ready = r0; out1_ready = r1; cnt_clr = clr;
      #1;
      check_outputs("");
      @(posedge clk);
      ox = (q.size() > 0) && (q[0].s ? r1 : r0);
      ix = iv && ((q.size() == 0) || ox);
      if (ox) begin
         s = q[0].s;
         $display("[TB] out%0d delivered %h", s, q[0].d);
         void'(q.pop_front());
         m_cnt[s] = (m_cnt[s] + 1) % CMOD;
      end
      if (clr) begin
         m_cnt[0] = 0;
         m_cnt[1] = 0;
      end
      if (ix) begin
         q.push_back('{d: id, s: is});
         m_buf = id;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      q.delete();
      m_buf = '0;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      check_outputs("rst_");
      $display("[TB] reset applied");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      m_buf = '0;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      @(negedge clk);
      do_reset();

      // single word to out0
      cycle(1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("t2_cnt0", 32'(cnt0), 32'd1);
      check_eq("t2_cnt1", 32'(cnt1), 32'd0);

      // alternating back-to-back stream
      cycle(1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("t3_cnt0", 32'(cnt0), 32'd3);
      check_eq("t3_cnt1", 32'(cnt1), 32'd2);

      // backpressure on out1, then release with refill on the same edge
      cycle(1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0);
         check_eq("t4_hold_data", 32'(out1_data), 32'h5);
      end
      cycle(1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("t4_loaded_next", 32'(out0_data), 32'h6);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);

      // reset while holding a word in FULL1
      cycle(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_reset();

      // counter wrap: 9 out0 transfers on a 3-bit counter
      for (int i = 0; i < 9; i++)
         cycle(1'b1, 4'(i), 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("t5_wrap_cnt0", 32'(cnt0), 32'd1);

      // clear coinciding with an out1 transfer
      cycle(1'b1, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("t6_cnt1", 32'(cnt1), 32'd0);
      check_eq("t6_empty", 32'(out1_valid), 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 40) == 0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
